// File: rtl/rom_arb_pkg.sv
// ---------------------------------------------------------------------------
// rom_arb_pkg
// Shared definitions for the instruction-ROM port arbiter:
//   - owner encoding of a ROM read (IFU or LSU)
//   - slot_t, one entry of the in-flight read tracker
//   - default byte address of ROM word 0
//   - kill_ifu_slot(), marks an in-flight IFU read as discarded on flush
// ---------------------------------------------------------------------------
package rom_arb_pkg;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [31:0] ROM_ARB_BASE_ADDR = 32'h0000_0000;

    // One ROM read travelling through the fixed read latency.
    // killed: the read still occupies the ROM slot but its data is dropped.
    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
        logic killed;
    } slot_t;

    // A flush discards IFU reads only; LSU reads always complete.
    function automatic slot_t kill_ifu_slot(input slot_t s, input logic flush);
        slot_t r;
        r = s;
        if (flush && s.valid && (s.owner == OWN_IFU)) begin
            r.killed = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_arb_inflight_pipe.sv
// ---------------------------------------------------------------------------
// rom_arb_inflight_pipe
// RD_LATENCY-deep shift register that follows each granted ROM read until
// its data appears on the ROM output. The last stage lines up exactly with
// the returning ROM word.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the pipe)
//   push_valid   a read is granted this cycle
//   push_owner   owner of the granted read (OWN_IFU / OWN_LSU)
//   push_err     granted read failed the address check
//   flush        IFU flush: kill every in-flight IFU read, including the push
//   tail         last stage, the read whose data is on the ROM output now
//   busy         at least one stage holds a read
// ---------------------------------------------------------------------------
module rom_arb_inflight_pipe
    import rom_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_valid,
    input  logic  push_owner,
    input  logic  push_err,
    input  logic  flush,
    output slot_t tail,
    output logic  busy
);

    slot_t stage [RD_LATENCY];
    slot_t push_slot;

    // An IFU grant in the flush cycle is killed on entry.
    always_comb begin
        push_slot.valid  = push_valid;
        push_slot.owner  = push_owner;
        push_slot.err    = push_err;
        push_slot.killed = flush && push_valid && (push_owner == OWN_IFU);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= push_slot;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= kill_ifu_slot(stage[i-1], flush);
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            busy = busy | stage[i].valid;
        end
    end

    assign tail = stage[RD_LATENCY-1];

endmodule

// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter
// Shares the single-port instruction ROM between the instruction fetch unit
// (IFU) and the load/store unit (LSU). Grants at most one fully pipelined
// read per cycle, drives all ROM control pins, and routes each returning
// word to the requester that issued it. IFU reads in flight can be flushed.
//
// Configuration macro:
//   ROM_ARB_IFU_PRIO_EN  defined   : fixed priority, IFU always wins
//                        undefined : round-robin between IFU and LSU
//
// Parameters: ADDR_WIDTH (ROM word address), DATA_WIDTH (ROM word),
//             RD_LATENCY (1 = no ROM output register, 2 = register on),
//             BASE_ADDR (byte address of ROM word 0, word aligned)
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   ifu_req_valid/ready/addr         IFU read request (byte address)
//   ifu_flush                        discard all IFU reads in flight
//   ifu_rsp_valid/data/err           IFU response, one-cycle strobe
//   lsu_req_valid/ready/addr         LSU read request (byte address)
//   lsu_rsp_valid/data/err           LSU response, one-cycle strobe
//   rom_addr, rom_clk_en             ROM word address, ROM clock enable
//   rom_addr_strobe                  high = ROM holds previous address
//   rom_rd_oce                       ROM output-register enable
//   rom_rd_data                      ROM read data
// ---------------------------------------------------------------------------
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR  = ROM_ARB_BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [31:0]           ifu_req_addr,
    input  logic                  ifu_flush,
    output logic                  ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rsp_data,
    output logic                  ifu_rsp_err,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [31:0]           lsu_req_addr,
    output logic                  lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rsp_data,
    output logic                  lsu_rsp_err,

    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_clk_en,
    output logic                  rom_addr_strobe,
    output logic                  rom_rd_oce,
    input  logic [DATA_WIDTH-1:0] rom_rd_data
);

    logic                  ifu_eligible;
    logic                  ifu_grant;
    logic                  lsu_grant;
    logic                  grant;
    logic                  grant_owner;
    logic [31:0]           sel_addr;
    logic [29:0]           word_off;
    logic                  addr_err;
    slot_t                 tail;
    logic                  busy;
    logic                  rsp_live;
    logic [DATA_WIDTH-1:0] rsp_word;
    logic [DATA_WIDTH-1:0] ifu_data_q;
    logic [DATA_WIDTH-1:0] lsu_data_q;

    // ---------------------------------------------------------------- issue
    // The IFU is blocked while it is being flushed; nothing is granted in
    // reset so every output reads 0 as soon as rst rises.
    assign ifu_eligible = ifu_req_valid && !ifu_flush && !rst;

`ifdef ROM_ARB_IFU_PRIO_EN
    // A flush-blocked IFU does not hold off the LSU.
    assign ifu_grant = ifu_eligible;
    assign lsu_grant = lsu_req_valid && !rst && !ifu_eligible;
`else
    // rr_next names the requester that wins the next contended cycle.
    logic rr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_next <= OWN_IFU;
        end else if (grant) begin
            rr_next <= ~grant_owner;
        end
    end

    assign ifu_grant = ifu_eligible && (!lsu_req_valid || (rr_next == OWN_IFU));
    assign lsu_grant = lsu_req_valid && !rst && (!ifu_eligible || (rr_next == OWN_LSU));
`endif

    assign ifu_req_ready = ifu_grant;
    assign lsu_req_ready = lsu_grant;
    assign grant         = ifu_grant || lsu_grant;
    assign grant_owner   = lsu_grant ? OWN_LSU : OWN_IFU;

    // -------------------------------------------------------- address check
    // ROM words sit on 4-byte boundaries, so the offset is taken in words;
    // the byte lanes only feed the alignment check.
    assign sel_addr = lsu_grant ? lsu_req_addr : ifu_req_addr;
    assign word_off = sel_addr[31:2] - BASE_ADDR[31:2];
    assign addr_err = (sel_addr[1:0] != 2'b00) || (word_off[29:ADDR_WIDTH] != '0);

    // ---------------------------------------------------------- ROM control
    // The strobe is also low in reset so that every output reads 0 there;
    // the ROM clock is disabled then, so the held address does not matter.
    assign rom_addr        = grant ? word_off[ADDR_WIDTH-1:0] : '0;
    assign rom_clk_en      = grant || busy;
    assign rom_addr_strobe = !grant && !rst;
    assign rom_rd_oce      = (RD_LATENCY == 2);

    rom_arb_inflight_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_inflight (
        .clk        (clk),
        .rst        (rst),
        .push_valid (grant),
        .push_owner (grant_owner),
        .push_err   (addr_err),
        .flush      (ifu_flush),
        .tail       (tail),
        .busy       (busy)
    );

    // ------------------------------------------------------------- response
    // A flush in the same cycle as an IFU response suppresses that response.
    assign rsp_live      = tail.valid && !tail.killed;
    assign rsp_word      = tail.err ? '0 : rom_rd_data;
    assign ifu_rsp_valid = rsp_live && (tail.owner == OWN_IFU) && !ifu_flush;
    assign lsu_rsp_valid = rsp_live && (tail.owner == OWN_LSU);
    assign ifu_rsp_err   = ifu_rsp_valid && tail.err;
    assign lsu_rsp_err   = lsu_rsp_valid && tail.err;

    // Response data is passed straight through on the strobe and the last
    // delivered word is held in between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_data_q <= '0;
            lsu_data_q <= '0;
        end else begin
            if (ifu_rsp_valid) begin
                ifu_data_q <= rsp_word;
            end
            if (lsu_rsp_valid) begin
                lsu_data_q <= rsp_word;
            end
        end
    end

    assign ifu_rsp_data = ifu_rsp_valid ? rsp_word : ifu_data_q;
    assign lsu_rsp_data = lsu_rsp_valid ? rsp_word : lsu_data_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_port_arbiter
// Two arbiters share clock and reset: instance 0 with RD_LATENCY=1 and
// instance 1 with RD_LATENCY=2, each in front of a small ROM model whose
// word i holds 32'hA500_0000 | i. Directed stimulus pushes the expected
// response (data, err, cycle it must appear) into a per-requester queue;
// a monitor on the falling edge pops and compares every response strobe.
// ---------------------------------------------------------------------------
module tb_rom_port_arbiter;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        ifu_req_valid   [2];
    logic        ifu_req_ready   [2];
    logic [31:0] ifu_req_addr    [2];
    logic        ifu_flush       [2];
    logic        ifu_rsp_valid   [2];
    logic [31:0] ifu_rsp_data    [2];
    logic        ifu_rsp_err     [2];
    logic        lsu_req_valid   [2];
    logic        lsu_req_ready   [2];
    logic [31:0] lsu_req_addr    [2];
    logic        lsu_rsp_valid   [2];
    logic [31:0] lsu_rsp_data    [2];
    logic        lsu_rsp_err     [2];
    logic [9:0]  rom_addr        [2];
    logic        rom_clk_en      [2];
    logic        rom_addr_strobe [2];
    logic        rom_rd_oce      [2];
    logic [31:0] rom_rd_data     [2];

    int   vectors;
    int   miscompares;
    int   cycle;
    exp_t exp_q [4][$];

    function automatic logic [31:0] romWord(input logic [9:0] a);
        return 32'hA500_0000 | {22'd0, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    for (genvar k = 0; k < 2; k++) begin : g_inst
        logic [31:0] q1;
        logic [31:0] q2;

        rom_port_arbiter #(
            .RD_LATENCY (k + 1)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .ifu_req_valid   (ifu_req_valid[k]),
            .ifu_req_ready   (ifu_req_ready[k]),
            .ifu_req_addr    (ifu_req_addr[k]),
            .ifu_flush       (ifu_flush[k]),
            .ifu_rsp_valid   (ifu_rsp_valid[k]),
            .ifu_rsp_data    (ifu_rsp_data[k]),
            .ifu_rsp_err     (ifu_rsp_err[k]),
            .lsu_req_valid   (lsu_req_valid[k]),
            .lsu_req_ready   (lsu_req_ready[k]),
            .lsu_req_addr    (lsu_req_addr[k]),
            .lsu_rsp_valid   (lsu_rsp_valid[k]),
            .lsu_rsp_data    (lsu_rsp_data[k]),
            .lsu_rsp_err     (lsu_rsp_err[k]),
            .rom_addr        (rom_addr[k]),
            .rom_clk_en      (rom_clk_en[k]),
            .rom_addr_strobe (rom_addr_strobe[k]),
            .rom_rd_oce      (rom_rd_oce[k]),
            .rom_rd_data     (rom_rd_data[k])
        );

        // Synchronous ROM: a low strobe loads a new address, a high strobe
        // re-reads the held one (q1 unchanged); q2 is the output register.
        always @(posedge clk) begin
            if (rom_clk_en[k]) begin
                if (!rom_addr_strobe[k]) begin
                    q1 <= romWord(rom_addr[k]);
                end
                if (rom_rd_oce[k]) begin
                    q2 <= q1;
                end
            end
        end

        assign rom_rd_data[k] = (k == 0) ? q1 : q2;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input int k, input logic iv, input logic [31:0] ia,
                                 input logic lv, input logic [31:0] la, input logic fl);
        ifu_req_valid[k] = iv;
        ifu_req_addr[k]  = ia;
        lsu_req_valid[k] = lv;
        lsu_req_addr[k]  = la;
        ifu_flush[k]     = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Checks the combinational grant a moment after the inputs settle.
    task automatic expectGrant(input int k, input logic ir, input logic lr, input logic [9:0] ra);
        #1;
        checkOutput($sformatf("k%0d ifu_req_ready", k), 32'(ifu_req_ready[k]), 32'(ir));
        checkOutput($sformatf("k%0d lsu_req_ready", k), 32'(lsu_req_ready[k]), 32'(lr));
        checkOutput($sformatf("k%0d rom_addr_strobe", k), 32'(rom_addr_strobe[k]), 32'(!(ir || lr)));
        if (ir || lr) begin
            checkOutput($sformatf("k%0d rom_addr", k), 32'(rom_addr[k]), 32'(ra));
            checkOutput($sformatf("k%0d rom_clk_en", k), 32'(rom_clk_en[k]), 32'd1);
        end
    endtask

    task automatic expectRsp(input int k, input logic lsu, input logic [31:0] addr, input logic err);
        exp_t e;
        e.due  = cycle + k + 1;
        e.err  = err;
        e.data = err ? 32'd0 : romWord(addr[11:2]);
        exp_q[k*2 + int'(lsu)].push_back(e);
    endtask

    task automatic doReset();
        rst = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: queue index = instance*2 + (0 IFU, 1 LSU).
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                int          qi;
                logic        v;
                logic        er;
                logic [31:0] d;
                exp_t        e;
                qi = k*2 + r;
                v  = (r == 1) ? lsu_rsp_valid[k] : ifu_rsp_valid[k];
                er = (r == 1) ? lsu_rsp_err[k]   : ifu_rsp_err[k];
                d  = (r == 1) ? lsu_rsp_data[k]  : ifu_rsp_data[k];
                while (exp_q[qi].size() > 0 && exp_q[qi][0].due < cycle) begin
                    e = exp_q[qi].pop_front();
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL rsp_missing q%0d: got no response, expected one at cycle %0d", qi, e.due);
                end
                if (v) begin
                    if (exp_q[qi].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL rsp_unexpected q%0d: got data %h at cycle %0d, expected none", qi, d, cycle);
                    end else begin
                        e = exp_q[qi].pop_front();
                        checkOutput($sformatf("q%0d rsp_data", qi), d, e.data);
                        checkOutput($sformatf("q%0d rsp_err", qi), 32'(er), 32'(e.err));
                        checkOutput($sformatf("q%0d rsp_cycle", qi), 32'(cycle), 32'(e.due));
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] rr_pat;
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        rst         = 1'b1;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(k, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        end

        // Reset state, with requests present on instance 0.
        applyStimulus(0, 1'b1, 32'h0, 1'b1, 32'h4, 1'b0);
        #1;
        checkOutput("reset ifu_req_ready", 32'(ifu_req_ready[0]), 32'd0);
        checkOutput("reset lsu_req_ready", 32'(lsu_req_ready[0]), 32'd0);
        checkOutput("reset rom_clk_en", 32'(rom_clk_en[0]), 32'd0);
        checkOutput("reset ifu_rsp_valid", 32'(ifu_rsp_valid[0]), 32'd0);
        checkOutput("reset rom_rd_oce lat1", 32'(rom_rd_oce[0]), 32'd0);
        checkOutput("rom_rd_oce lat2", 32'(rom_rd_oce[1]), 32'd1);
        applyStimulus(0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;

        // Latency 1: IFU back-to-back reads of words 0, 1, 2.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 32'(i*4), 1'b0, 32'd0, 1'b0);
            expectGrant(0, 1'b1, 1'b0, 10'(i));
            expectRsp(0, 1'b0, 32'(i*4), 1'b0);
            nextCycle();
        end
        applyStimulus(0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("ifu_rsp_data hold", ifu_rsp_data[0], 32'hA500_0002);

        // Round-robin from reset: IFU 0x10 (word 4) vs LSU 0x20 (word 8).
        doReset();
        rr_pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
            expectGrant(0, rr_pat[i], !rr_pat[i], rr_pat[i] ? 10'd4 : 10'd8);
            expectRsp(0, !rr_pat[i], rr_pat[i] ? 32'h10 : 32'h20, 1'b0);
            nextCycle();
        end

        // Address check: misaligned, out of range, last word, IFU misaligned.
        applyStimulus(0, 1'b0, 32'd0, 1'b1, 32'h1002, 1'b0);
        expectGrant(0, 1'b0, 1'b1, 10'd0);
        expectRsp(0, 1'b1, 32'h1002, 1'b1);
        nextCycle();
        applyStimulus(0, 1'b0, 32'd0, 1'b1, 32'h1000, 1'b0);
        expectGrant(0, 1'b0, 1'b1, 10'd0);
        expectRsp(0, 1'b1, 32'h1000, 1'b1);
        nextCycle();
        applyStimulus(0, 1'b0, 32'd0, 1'b1, 32'hFFC, 1'b0);
        expectGrant(0, 1'b0, 1'b1, 10'h3FF);
        expectRsp(0, 1'b1, 32'hFFC, 1'b0);
        nextCycle();
        applyStimulus(0, 1'b1, 32'h2, 1'b0, 32'd0, 1'b0);
        expectGrant(0, 1'b1, 1'b0, 10'd0);
        expectRsp(0, 1'b0, 32'h2, 1'b1);
        nextCycle();

        // Latency 1: flush while the IFU word is on the output suppresses it.
        applyStimulus(0, 1'b1, 32'h4, 1'b0, 32'd0, 1'b0);
        expectGrant(0, 1'b1, 1'b0, 10'd1);
        nextCycle();
        applyStimulus(0, 1'b1, 32'h8, 1'b0, 32'd0, 1'b1);
        expectGrant(0, 1'b0, 1'b0, 10'd0);
        checkOutput("flush suppresses ifu_rsp_valid", 32'(ifu_rsp_valid[0]), 32'd0);
        nextCycle();
        applyStimulus(0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        // Latency 2: IFU 0x40 then flush; LSU 0x44 granted in the flush cycle.
        applyStimulus(1, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0);
        expectGrant(1, 1'b1, 1'b0, 10'h10);
        nextCycle();
        applyStimulus(1, 1'b1, 32'h48, 1'b1, 32'h44, 1'b1);
        expectGrant(1, 1'b0, 1'b1, 10'h11);
        expectRsp(1, 1'b1, 32'h44, 1'b0);
        nextCycle();
        applyStimulus(1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        repeat (4) nextCycle();

        // Latency 2: reset with two reads in flight, last grant to the IFU.
        applyStimulus(1, 1'b0, 32'd0, 1'b1, 32'h84, 1'b0);
        expectGrant(1, 1'b0, 1'b1, 10'h21);
        nextCycle();
        applyStimulus(1, 1'b1, 32'h80, 1'b0, 32'd0, 1'b0);
        expectGrant(1, 1'b1, 1'b0, 10'h20);
        nextCycle();
        applyStimulus(1, 1'b1, 32'h80, 1'b1, 32'h84, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst ifu_req_ready", 32'(ifu_req_ready[1]), 32'd0);
        checkOutput("rst lsu_req_ready", 32'(lsu_req_ready[1]), 32'd0);
        checkOutput("rst lsu_rsp_valid", 32'(lsu_rsp_valid[1]), 32'd0);
        checkOutput("rst lsu_rsp_data", lsu_rsp_data[1], 32'd0);
        checkOutput("rst ifu_rsp_data", ifu_rsp_data[1], 32'd0);
        checkOutput("rst rom_clk_en", 32'(rom_clk_en[1]), 32'd0);
        checkOutput("rst rom_addr", 32'(rom_addr[1]), 32'd0);
        applyStimulus(1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        repeat (4) nextCycle();
        applyStimulus(1, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0);
        expectGrant(1, 1'b1, 1'b0, 10'h40);
        expectRsp(1, 1'b0, 32'h100, 1'b0);
        nextCycle();
        applyStimulus(1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        repeat (5) nextCycle();

        for (int q = 0; q < 4; q++) begin
            checkOutput($sformatf("q%0d drained", q), 32'(exp_q[q].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 50000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port 32x1024 instruction ROM between two requesters: the instruction fetch unit (IFU) and the load/store unit (LSU), which reads constant tables from the ROM.
- Owns all ROM control pins (addr, clk_en, addr_strobe, rd_oce).
- Tracks in-flight reads through the fixed ROM latency and routes each returning word to the requester that issued it.
- Supports IFU flush on redirect.

Parameters:
- ADDR_WIDTH, 10, ROM word-address width.
- DATA_WIDTH, 32, ROM word width.
- RD_LATENCY, 1, ROM read latency in cycles. Legal values: 1 (no output register) or 2 (ROM output register on). Must match the ROM instance.
- BASE_ADDR, 32'h0000_0000, byte address of ROM word 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  request accepted this cycle.
- ifu_req_addr  in  32  IFU byte address.
- ifu_flush  in  1  discard all IFU reads in flight.
- ifu_rsp_valid  out  1  IFU response strobe, one cycle.
- ifu_rsp_data  out  DATA_WIDTH  IFU read data.
- ifu_rsp_err  out  1  address out of range or misaligned.
- lsu_req_valid  in  1  LSU read request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_req_addr  in  32  LSU byte address.
- lsu_rsp_valid  out  1  LSU response strobe.
- lsu_rsp_data  out  DATA_WIDTH  LSU read data.
- lsu_rsp_err  out  1  LSU error.
- rom_addr  out  ADDR_WIDTH  ROM word address.
- rom_clk_en  out  1  ROM clock enable.
- rom_addr_strobe  out  1  ROM address strobe; high means hold the previous address.
- rom_rd_oce  out  1  ROM output-register enable.
- rom_rd_data  in  DATA_WIDTH  ROM read data.

Behaviour:
- Reset values: all outputs 0, round-robin pointer = IFU, in-flight pipeline empty.
- Issue:
  - At most one grant per cycle.
  - req_ready is combinational from valid and the arbiter state. A transfer occurs when valid and ready are both high.
  - Requests are fully pipelined, so a new grant is allowed every cycle.
- Arbitration: round-robin.
  - When both requesters are valid, grant the one not granted last.
  - A single valid requester always wins.
  - The pointer updates only on a grant.
- Address check:
  - offset = addr - BASE_ADDR.
  - err = (addr[1:0] != 0) or (offset[31:ADDR_WIDTH+2] != 0).
  - rom_addr = offset[ADDR_WIDTH+1:2].
- ROM control:
  - rom_clk_en = 1 on any grant or while any slot is in flight.
  - rom_addr_strobe = 0 on a grant, 1 otherwise.
  - rom_rd_oce = 1 when RD_LATENCY=2; tie 0 when RD_LATENCY=1.
  - An erroring request still occupies its slot but returns data 0.
- Tracking: shift register of RD_LATENCY stages. Each stage holds {valid, owner, err, killed}.
- Response:
  - When the last stage is valid and not killed, assert the owner's rsp_valid for exactly 1 cycle.
  - rsp_data = err ? 0 : rom_rd_data.
  - rsp_data holds its value when rsp_valid is low.
  - Total latency: grant edge to rsp_valid = RD_LATENCY cycles.
- Flush:
  - ifu_flush sets killed on every in-flight IFU slot, including an IFU grant made in the same cycle.
  - ifu_req_ready is forced 0 during the flush cycle.
  - LSU slots are unaffected; the LSU may be granted in the flush cycle.
- Simultaneous events:
  - A response from the last stage and a new grant in the same cycle are both legal.
  - ifu_flush while an IFU response is on the output in the same cycle: that response is suppressed.
- No response backpressure: requesters must accept every rsp_valid.
- Reset mid-operation clears all in-flight slots. No response is emitted for them.

Optional Feature:
- Macro: ROM_ARB_IFU_PRIO_EN.
- Defined: fixed priority. The IFU always wins when valid, and the LSU is granted only when ifu_req_valid=0. The round-robin pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- Shared package rom_arb_pkg holds:
  - owner encoding: OWN_IFU=1'b0, OWN_LSU=1'b1.
  - the slot struct typedef {valid, owner, err, killed}.
  - the default BASE_ADDR constant.
- One natural sub-module, rom_arb_inflight_pipe: the RD_LATENCY-deep slot shift register with flush-kill logic.
- Arbiter, address check and response mux stay in the top level.

Test Plan:
- RD_LATENCY=1, IFU-only reads at 0x0, 0x4, 0x8 on back-to-back cycles -> ifu_rsp_valid high on the 3 following cycles with words 0, 1, 2; rom_addr_strobe=0 on each grant.
- Both requesters valid for 4 cycles (IFU 0x10, LSU 0x20) -> grants alternate IFU, LSU, IFU, LSU. Then rerun with ROM_ARB_IFU_PRIO_EN -> 4 IFU grants, lsu_req_ready=0 throughout.
- RD_LATENCY=2: IFU read 0x40, then ifu_flush asserted 1 cycle later -> no ifu_rsp_valid. An LSU read of 0x44 granted in the flush cycle returns word 17 two cycles later.
- LSU reads of 0x1002 (misaligned) and BASE_ADDR+0x1000 (out of range) -> lsu_rsp_err=1, data 0, latency unchanged.
- rst pulsed while 2 reads are in flight at RD_LATENCY=2 -> all outputs 0 immediately, no responses after reset release, and the first grant after reset goes to the IFU.
